// File: rtl/axi4s_video_tpg.sv
// AXI4-Stream video test-pattern generator.
// Emits width x height RGB888 frames with TUSER on the first pixel and TLAST
// at end of line, honours TREADY backpressure and idles for a programmable
// gap between frames. All stream outputs are registered.
module axi4s_video_tpg #(
  parameter int unsigned DW = 32
) (
  input  logic          ACLK,
  input  logic          ARESETn,
  input  logic          cfg_enable,
  input  logic [1:0]    cfg_pattern,
  input  logic [23:0]   cfg_color,
  input  logic [11:0]   cfg_width,
  input  logic [11:0]   cfg_height,
  input  logic [15:0]   cfg_gap,
  output logic [DW-1:0] TDATA,
  output logic [3:0]    TKEEP,
  output logic          TLAST,
  output logic          TUSER,
  output logic          TVALID,
  input  logic          TREADY,
  output logic [15:0]   frame_cnt,
  output logic          busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_GAP} state_t;

  state_t        r_state;
  logic          r_busy;
  logic [1:0]    r_pat;
  logic [23:0]   r_color;
  logic [11:0]   r_w;
  logic [11:0]   r_h;
  logic [15:0]   r_gap;
  logic [15:0]   r_gap_cnt;
  logic [11:0]   r_x;
  logic [11:0]   r_y;
  logic          r_valid;
  logic          r_last;
  logic          r_user;
  logic [DW-1:0] r_data;
  logic [15:0]   r_frame_cnt;

  logic          w_cfg_ok;
  logic          w_accept;
  logic          w_last_x;
  logic          w_frame_end;
  logic          w_start;
  logic [11:0]   w_nx;
  logic [11:0]   w_ny;

  function automatic logic [23:0] f_pixel(input logic [1:0]  pat,
                                          input logic [23:0] color,
                                          input logic [7:0]  x,
                                          input logic [7:0]  y);
    logic [23:0] p;
    case (pat)
      2'd0:    p = color;
      2'd1:    p = {3{x}};
      2'd2:    p = {3{y}};
      default: p = (x[4] ^ y[4]) ? '1 : '0;
    endcase
    return p;
  endfunction

  function automatic logic [DW-1:0] f_widen(input logic [23:0] p);
    logic [DW-1:0] v;
    v = '0;
    v[23:0] = p;
    return v;
  endfunction

  // Beat acceptance, next-coordinate and frame-start decisions.
  // Every path that begins a frame (from IDLE, back-to-back, or after the gap)
  // funnels through w_start so the latch/first-beat logic exists once.
  always_comb begin
    w_cfg_ok    = cfg_enable && (cfg_width != '0) && (cfg_height != '0);
    w_accept    = r_valid && TREADY;
    w_last_x    = (r_x == r_w - 12'd1);
    w_frame_end = (r_state == S_ACTIVE) && w_accept && w_last_x &&
                  (r_y == r_h - 12'd1);
    w_nx        = w_last_x ? '0 : r_x + 12'd1;
    w_ny        = w_last_x ? r_y + 12'd1 : r_y;
    w_start     = w_cfg_ok &&
                  ((r_state == S_IDLE) ||
                   (w_frame_end && (r_gap == '0)) ||
                   ((r_state == S_GAP) && (r_gap_cnt == 16'd1)));
  end

  // Frame state machine with registered stream outputs.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_pat       <= '0;
      r_color     <= '0;
      r_w         <= '0;
      r_h         <= '0;
      r_gap       <= '0;
      r_gap_cnt   <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_user      <= 1'b0;
      r_data      <= '0;
      r_frame_cnt <= '0;
    end else if (w_start) begin
      r_state <= S_ACTIVE;
      r_busy  <= 1'b1;
      r_pat   <= cfg_pattern;
      r_color <= cfg_color;
      r_w     <= cfg_width;
      r_h     <= cfg_height;
      r_gap   <= cfg_gap;
      r_x     <= '0;
      r_y     <= '0;
      r_valid <= 1'b1;
      r_user  <= 1'b1;
      r_last  <= (cfg_width == 12'd1);
      r_data  <= f_widen(f_pixel(cfg_pattern, cfg_color, 8'd0, 8'd0));
      if (w_frame_end)
        r_frame_cnt <= r_frame_cnt + 16'd1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_busy <= 1'b0;
        end
        S_ACTIVE: begin
          if (w_accept) begin
            if (w_frame_end) begin
              r_frame_cnt <= r_frame_cnt + 16'd1;
              r_valid     <= 1'b0;
              r_last      <= 1'b0;
              r_user      <= 1'b0;
              if (r_gap != '0) begin
                r_state   <= S_GAP;
                r_gap_cnt <= r_gap;
              end else begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_x    <= w_nx;
              r_y    <= w_ny;
              r_user <= 1'b0;
              r_last <= (w_nx == r_w - 12'd1);
              r_data <= f_widen(f_pixel(r_pat, r_color, w_nx[7:0], w_ny[7:0]));
            end
          end
        end
        S_GAP: begin
          if (r_gap_cnt == 16'd1) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt - 16'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign TDATA     = r_data;
  assign TKEEP     = 4'hF;
  assign TLAST     = r_last;
  assign TUSER     = r_user;
  assign TVALID    = r_valid;
  assign frame_cnt = r_frame_cnt;
  assign busy      = r_busy;

endmodule

// File: tb/tb_axi4s_video_tpg.sv
// Directed testbench for axi4s_video_tpg.
module tb_axi4s_video_tpg;

  logic        clk = 1'b0;
  logic        ARESETn;
  logic        cfg_enable;
  logic [1:0]  cfg_pattern;
  logic [23:0] cfg_color;
  logic [11:0] cfg_width;
  logic [11:0] cfg_height;
  logic [15:0] cfg_gap;
  logic [31:0] TDATA;
  logic [3:0]  TKEEP;
  logic        TLAST;
  logic        TUSER;
  logic        TVALID;
  logic        TREADY;
  logic [15:0] frame_cnt;
  logic        busy;

  always #5 clk = ~clk;

  axi4s_video_tpg #(.DW(32)) u_dut (
    .ACLK(clk), .ARESETn(ARESETn), .cfg_enable(cfg_enable),
    .cfg_pattern(cfg_pattern), .cfg_color(cfg_color), .cfg_width(cfg_width),
    .cfg_height(cfg_height), .cfg_gap(cfg_gap), .TDATA(TDATA), .TKEEP(TKEEP),
    .TLAST(TLAST), .TUSER(TUSER), .TVALID(TVALID), .TREADY(TREADY),
    .frame_cnt(frame_cnt), .busy(busy)
  );

  typedef struct {
    logic [31:0] d;
    logic        l;
    logic        u;
    logic        b;
    int          c;
  } beat_t;

  beat_t       q[$];
  int          cyc = 0;
  int          n_unstable = 0;
  logic        p_stall = 1'b0;
  logic [34:0] p_snap;
  int          n_chk = 0;
  int          n_pass = 0;

  // Record every accepted beat and flag any output change while stalled.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (ARESETn) begin
      if (p_stall && ({TVALID, TDATA, TLAST, TUSER} != p_snap))
        n_unstable = n_unstable + 1;
      if (TVALID && TREADY)
        q.push_back('{d: TDATA, l: TLAST, u: TUSER, b: busy, c: cyc});
      p_stall = TVALID && !TREADY;
      p_snap  = {TVALID, TDATA, TLAST, TUSER};
    end else begin
      p_stall = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic setup(input logic [1:0] pat, input logic [23:0] col,
                       input logic [11:0] w, input logic [11:0] h, input logic [15:0] g);
    cfg_pattern = pat; cfg_color = col; cfg_width = w; cfg_height = h; cfg_gap = g;
    q.delete();
  endtask

  // Runs from a negedge until n beats are accepted; optionally drops enable or
  // switches to the vertical ramp once a given number of beats has been seen.
  task automatic wait_beats(input int n, input int drop_at, input int chg_at, input bit rnd);
    for (int i = 0; i < 2000; i++) begin
      if (q.size() == chg_at) cfg_pattern = 2'd2;
      if (q.size() == drop_at) cfg_enable = 1'b0;
      if (q.size() >= n) break;
      TREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
    end
    TREADY = 1'b1;
    chk("beat_count", q.size(), n);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    chk("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  int          exp_fc = 0;
  int          n_hi;
  logic [31:0] ev;

  initial begin
    ARESETn = 1'b0; cfg_enable = 1'b0; TREADY = 1'b1;
    setup(2'd1, 24'h0, 12'd4, 12'd2, 16'd0);
    repeat (3) @(negedge clk);
    chk("rst_tvalid", {31'd0, TVALID}, 32'd0);
    chk("rst_tlast", {31'd0, TLAST}, 32'd0);
    chk("rst_tuser", {31'd0, TUSER}, 32'd0);
    chk("rst_tdata", TDATA, 32'd0);
    chk("rst_fcnt", {16'd0, frame_cnt}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("tkeep", {28'd0, TKEEP}, 32'hF);
    ARESETn = 1'b1;
    @(negedge clk);

    // 4x2 horizontal ramp, single frame, TREADY high.
    cfg_enable = 1'b1;
    @(negedge clk);
    chk("first_tvalid", {31'd0, TVALID}, 32'd1);
    chk("first_tuser", {31'd0, TUSER}, 32'd1);
    chk("first_busy", {31'd0, busy}, 32'd1);
    cfg_enable = 1'b0;
    wait_beats(8, -1, -1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk("hr_data", q[i].d, (i % 4) * 32'h010101);
      chk("hr_last", {31'd0, q[i].l}, (i % 4 == 3) ? 32'd1 : 32'd0);
      chk("hr_user", {31'd0, q[i].u}, (i == 0) ? 32'd1 : 32'd0);
    end
    exp_fc = 1;
    chk("hr_fcnt", {16'd0, frame_cnt}, exp_fc);
    chk("hr_busy_last", {31'd0, q[7].b}, 32'd1);
    chk("hr_busy_fall", {31'd0, busy}, 32'd0);
    chk("hr_tvalid_off", {31'd0, TVALID}, 32'd0);

    // Same frame under random backpressure.
    setup(2'd1, 24'h0, 12'd4, 12'd2, 16'd0);
    n_unstable = 0;
    cfg_enable = 1'b1;
    wait_beats(8, 1, -1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk("bp_data", q[i].d, (i % 4) * 32'h010101);
      chk("bp_last", {31'd0, q[i].l}, (i % 4 == 3) ? 32'd1 : 32'd0);
      chk("bp_user", {31'd0, q[i].u}, (i == 0) ? 32'd1 : 32'd0);
    end
    chk("bp_stable", n_unstable, 32'd0);
    wait_idle();
    exp_fc = 2;
    chk("bp_fcnt", {16'd0, frame_cnt}, exp_fc);

    // 2x2 solid, gap 3, continuous enable.
    setup(2'd0, 24'h123456, 12'd2, 12'd2, 16'd3);
    cfg_enable = 1'b1;
    wait_beats(8, 8, -1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk("g3_data", q[i].d, 32'h00123456);
      chk("g3_last", {31'd0, q[i].l}, (i % 2 == 1) ? 32'd1 : 32'd0);
    end
    chk("g3_user2", {31'd0, q[4].u}, 32'd1);
    chk("g3_gap", q[4].c - q[3].c, 32'd4);
    chk("g3_inframe", q[3].c - q[0].c, 32'd3);
    wait_idle();
    exp_fc = 4;
    chk("g3_fcnt", {16'd0, frame_cnt}, exp_fc);

    // Same with gap 0: back-to-back frames.
    setup(2'd0, 24'h123456, 12'd2, 12'd2, 16'd0);
    cfg_enable = 1'b1;
    wait_beats(8, 5, -1, 1'b0);
    chk("g0_gap", q[4].c - q[3].c, 32'd1);
    chk("g0_span", q[7].c - q[0].c, 32'd7);
    chk("g0_user2", {31'd0, q[4].u}, 32'd1);
    wait_idle();
    exp_fc = 6;
    chk("g0_fcnt", {16'd0, frame_cnt}, exp_fc);

    // 4x4 vertical ramp, enable dropped after beat 2.
    setup(2'd2, 24'h0, 12'd4, 12'd4, 16'd0);
    cfg_enable = 1'b1;
    wait_beats(16, 2, -1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      chk("vr_data", q[i].d, (i / 4) * 32'h010101);
      chk("vr_last", {31'd0, q[i].l}, (i % 4 == 3) ? 32'd1 : 32'd0);
    end
    repeat (5) @(negedge clk);
    chk("vr_no_extra", q.size(), 32'd16);
    chk("vr_busy", {31'd0, busy}, 32'd0);
    exp_fc = 7;
    chk("vr_fcnt", {16'd0, frame_cnt}, exp_fc);

    // Pattern switched mid-frame only takes effect on the next frame.
    setup(2'd1, 24'h0, 12'd4, 12'd2, 16'd0);
    cfg_enable = 1'b1;
    wait_beats(16, 10, 2, 1'b0);
    for (int i = 0; i < 16; i++) begin
      ev = (i < 8) ? (i % 4) * 32'h010101 : ((i - 8) / 4) * 32'h010101;
      chk("pc_data", q[i].d, ev);
    end
    wait_idle();

    // Checkerboard 18x1: x[4] flips at pixel 16.
    setup(2'd3, 24'h0, 12'd18, 12'd1, 16'd0);
    cfg_enable = 1'b1;
    wait_beats(18, 1, -1, 1'b0);
    chk("cb_px15", q[15].d, 32'h0);
    chk("cb_px16", q[16].d, 32'hFFFFFF);
    chk("cb_px17_last", {31'd0, q[17].l}, 32'd1);
    wait_idle();

    // Reset asserted during line 1 of a 4x4 frame.
    setup(2'd1, 24'h0, 12'd4, 12'd4, 16'd0);
    cfg_enable = 1'b1;
    wait_beats(6, -1, -1, 1'b0);
    ARESETn = 1'b0;
    @(negedge clk);
    chk("mr_tvalid", {31'd0, TVALID}, 32'd0);
    chk("mr_fcnt", {16'd0, frame_cnt}, 32'd0);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    ARESETn = 1'b1;
    q.delete();
    wait_beats(16, 1, -1, 1'b0);
    chk("mr_restart_user", {31'd0, q[0].u}, 32'd1);
    chk("mr_restart_data", q[0].d, 32'h0);
    chk("mr_end_data", q[15].d, 32'h030303);
    wait_idle();
    chk("mr_fcnt_after", {16'd0, frame_cnt}, 32'd1);

    // 1x1 frame: single beat carries both flags.
    setup(2'd0, 24'hABCDEF, 12'd1, 12'd1, 16'd0);
    cfg_enable = 1'b1;
    @(negedge clk);
    cfg_enable = 1'b0;
    chk("one_tuser", {31'd0, TUSER}, 32'd1);
    chk("one_tlast", {31'd0, TLAST}, 32'd1);
    chk("one_data", TDATA, 32'h00ABCDEF);
    @(negedge clk);
    chk("one_done", {31'd0, TVALID}, 32'd0);
    chk("one_fcnt", {16'd0, frame_cnt}, 32'd2);

    // Zero width never starts a frame.
    setup(2'd0, 24'h0, 12'd0, 12'd4, 16'd0);
    cfg_enable = 1'b1;
    n_hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (TVALID || busy) n_hi = n_hi + 1;
    end
    cfg_enable = 1'b0;
    chk("w0_never_valid", n_hi, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
